// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome beat sequencer.
// Holds the sequencer state encoding, beat limits and click counter sizing.
package metronome_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLICK = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    localparam int SEQ_MAX_BEATS     = 16;
    localparam int SEQ_DEFAULT_BEATS = 4;
    localparam int BEATS_W           = 5;
    localparam int INDEX_W           = 4;

    // Counter must hold the longer of the two click lengths.
    function automatic int click_cnt_w(input int accent_len, input int click_len);
        int longest;
        longest = (accent_len > click_len) ? accent_len : click_len;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/click_pulse_gen.sv
// Loadable down-counter that holds o_busy high for exactly i_len cycles after a load.
// A load while busy restarts the count; i_clear drops the pulse at once.
module click_pulse_gen #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_last
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count  <= '0;
            o_busy <= 1'b0;
        end else if (i_clear) begin
            count  <= '0;
            o_busy <= 1'b0;
        end else if (i_load) begin
            count  <= i_len;
            o_busy <= (i_len != '0);
        end else if (o_busy) begin
            count  <= count - LEN_W'(1);
            o_busy <= (count != LEN_W'(1));
        end
    end

    assign o_last = o_busy && (count == LEN_W'(1));

endmodule

// File: rtl/beat_sequencer.sv
// Run/stop bar sequencer: beat index, accented downbeat clicks, bar count and sync pulse.
// All outputs registered one clock after their cause; beats-per-bar changes wait for the bar wrap.
module beat_sequencer
    import metronome_pkg::*;
#(
    parameter int CLICK_LEN     = 50000,
    parameter int ACCENT_LEN    = 100000,
    parameter int MAX_BEATS     = SEQ_MAX_BEATS,
    parameter int DEFAULT_BEATS = SEQ_DEFAULT_BEATS,
    parameter int BAR_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run_toggle,
    input  logic             i_trigger,
    input  logic             i_cfg_valid,
    input  logic [4:0]       i_cfg_beats,
    output logic             o_running,
    output logic             o_sync,
    output logic             o_click,
    output logic             o_accent,
    output logic [3:0]       o_beat_index,
    output logic [BAR_W-1:0] o_bar_count,
    output logic             o_cfg_pending,
    output logic             o_overrun
);

    localparam int CNT_W = click_cnt_w(ACCENT_LEN, CLICK_LEN);

    seq_state_t           state, state_nxt;
    logic                 start, stop, advance;
    logic                 cfg_legal, wrap;
    logic [BEATS_W-1:0]   active_beats;
    logic [BEATS_W-1:0]   pend_beats;
    logic [INDEX_W-1:0]   index_nxt;
    logic                 click_load, click_last;
    logic [CNT_W-1:0]     click_len;

    assign cfg_legal = i_cfg_valid && (i_cfg_beats != '0) && (int'(i_cfg_beats) <= MAX_BEATS);
    assign wrap      = ({1'b0, o_beat_index} == (active_beats - BEATS_W'(1)));
    assign index_nxt = wrap ? '0 : (o_beat_index + INDEX_W'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run toggle outranks a coincident trigger in every running state.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (i_run_toggle) begin
                    state_nxt = CLICK;
                    start     = 1'b1;
                end
            end
            CLICK: begin
                if (i_run_toggle) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (i_trigger) begin
                    advance = 1'b1;
                end else if (click_last) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_run_toggle) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (i_trigger) begin
                    state_nxt = CLICK;
                    advance   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign click_load = start || advance;
    assign click_len  = (start || wrap) ? CNT_W'(ACCENT_LEN) : CNT_W'(CLICK_LEN);

    click_pulse_gen #(
        .LEN_W (CNT_W)
    ) u_click (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (click_load),
        .i_clear (stop),
        .i_len   (click_len),
        .o_busy  (o_click),
        .o_last  (click_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_running    <= 1'b0;
            o_sync       <= 1'b0;
            o_accent     <= 1'b0;
            o_beat_index <= '0;
            o_bar_count  <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_sync    <= start;
            o_overrun <= advance && (state == CLICK);
            if (start) begin
                o_running    <= 1'b1;
                o_beat_index <= '0;
                o_bar_count  <= '0;
                o_accent     <= 1'b1;
            end else if (stop) begin
                o_running    <= 1'b0;
                o_beat_index <= '0;
                o_bar_count  <= '0;
                o_accent     <= 1'b0;
            end else if (advance) begin
                o_beat_index <= index_nxt;
                o_accent     <= wrap;
                if (wrap) begin
                    o_bar_count <= o_bar_count + BAR_W'(1);
                end
            end else if ((state == CLICK) && click_last) begin
                o_accent <= 1'b0;
            end
        end
    end

    // A strobe landing on the wrap or the stop wins over the older pending value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            active_beats  <= BEATS_W'(DEFAULT_BEATS);
            pend_beats    <= '0;
            o_cfg_pending <= 1'b0;
        end else if (state == IDLE) begin
            if (cfg_legal) begin
                active_beats <= i_cfg_beats;
            end
        end else if (stop || (advance && wrap)) begin
            if (cfg_legal) begin
                active_beats <= i_cfg_beats;
            end else if (o_cfg_pending) begin
                active_beats <= pend_beats;
            end
            o_cfg_pending <= 1'b0;
        end else if (cfg_legal) begin
            pend_beats    <= i_cfg_beats;
            o_cfg_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: cycle-level reference model plus a beat scoreboard.
module tb_beat_sequencer;

    localparam int CLEN = 4;
    localparam int ALEN = 8;

    typedef struct {
        logic [3:0]  idx;
        logic        acc;
        logic [15:0] bar;
        int          len;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_run_toggle = 1'b0;
    logic        i_trigger = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic [4:0]  i_cfg_beats = '0;
    logic        o_running, o_sync, o_click, o_accent, o_cfg_pending, o_overrun;
    logic [3:0]  o_beat_index;
    logic [15:0] o_bar_count;

    beat_sequencer #(
        .CLICK_LEN     (CLEN),
        .ACCENT_LEN    (ALEN),
        .MAX_BEATS     (16),
        .DEFAULT_BEATS (4),
        .BAR_W         (16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run_toggle  (i_run_toggle),
        .i_trigger     (i_trigger),
        .i_cfg_valid   (i_cfg_valid),
        .i_cfg_beats   (i_cfg_beats),
        .o_running     (o_running),
        .o_sync        (o_sync),
        .o_click       (o_click),
        .o_accent      (o_accent),
        .o_beat_index  (o_beat_index),
        .o_bar_count   (o_bar_count),
        .o_cfg_pending (o_cfg_pending),
        .o_overrun     (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    beat_t       exp_q[$];
    logic        m_run = 1'b0;
    logic [3:0]  m_idx = '0;
    logic [15:0] m_bar = '0;
    logic [4:0]  m_active = 5'd4;
    logic [4:0]  m_pend = '0;
    logic        m_pv = 1'b0;
    int          m_left = 0;
    int          m_cur_len = 0;

    task automatic model_reset();
        m_run = 1'b0; m_idx = '0; m_bar = '0; m_active = 5'd4;
        m_pend = '0; m_pv = 1'b0; m_left = 0; m_cur_len = 0;
        exp_q.delete();
    endtask

    task automatic load_beat();
        beat_t b;
        m_cur_len = (m_idx == 4'd0) ? ALEN : CLEN;
        m_left    = m_cur_len;
        b.idx = m_idx; b.acc = (m_idx == 4'd0); b.bar = m_bar; b.len = m_cur_len;
        exp_q.push_back(b);
    endtask

    // Beat in progress is cut short: it was high for the cycles already elapsed.
    task automatic truncate_beat();
        if (m_left > 0 && exp_q.size() > 0)
            exp_q[exp_q.size()-1].len = m_cur_len - m_left + 1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_running"}, o_running, 0);
        check({tag, "_sync"}, o_sync, 0);
        check({tag, "_click"}, o_click, 0);
        check({tag, "_accent"}, o_accent, 0);
        check({tag, "_index"}, o_beat_index, 0);
        check({tag, "_bar"}, o_bar_count, 0);
        check({tag, "_pending"}, o_cfg_pending, 0);
        check({tag, "_overrun"}, o_overrun, 0);
    endtask

    // One clock of stimulus; model updated, then every output checked after the edge.
    task automatic cyc(input bit trig, input bit tog, input bit cv, input logic [4:0] cb);
        bit legal, wrap, exp_sync, exp_ovr;
        legal    = cv && (cb >= 5'd1) && (cb <= 5'd16);
        exp_sync = 1'b0;
        exp_ovr  = 1'b0;
        if (!m_run) begin
            if (legal) m_active = cb;
            if (tog) begin
                m_run = 1'b1; m_idx = '0; m_bar = '0; exp_sync = 1'b1;
                load_beat();
            end
        end else if (tog) begin
            if (legal) m_active = cb;
            else if (m_pv) m_active = m_pend;
            m_pv = 1'b0; m_run = 1'b0; m_idx = '0; m_bar = '0;
            truncate_beat();
            m_left = 0;
        end else begin
            wrap = trig && ({1'b0, m_idx} == (m_active - 5'd1));
            if (wrap) begin
                if (legal) m_active = cb;
                else if (m_pv) m_active = m_pend;
                m_pv = 1'b0;
            end else if (legal) begin
                m_pend = cb; m_pv = 1'b1;
            end
            if (trig) begin
                if (m_left > 0) begin
                    exp_ovr = 1'b1;
                    truncate_beat();
                end
                m_idx = wrap ? 4'd0 : 4'(m_idx + 4'd1);
                if (wrap) m_bar = 16'(m_bar + 16'd1);
                load_beat();
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        i_trigger = trig; i_run_toggle = tog; i_cfg_valid = cv; i_cfg_beats = cb;
        @(posedge i_clk);
        #1;
        i_trigger = 1'b0; i_run_toggle = 1'b0; i_cfg_valid = 1'b0; i_cfg_beats = '0;
        check("sync", o_sync, exp_sync);
        check("running", o_running, m_run);
        check("click", o_click, m_left > 0);
        check("accent", o_accent, (m_left > 0) && (m_idx == 4'd0));
        check("index", o_beat_index, m_idx);
        check("bar", o_bar_count, m_bar);
        check("pending", o_cfg_pending, m_pv);
        check("overrun", o_overrun, exp_ovr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            idle(19);
            cyc(1'b1, 1'b0, 1'b0, 5'd0);
        end
    endtask

    // Beat monitor: each click segment is compared against the scoreboard head.
    bit          mon_on = 1'b0;
    logic [3:0]  obs_idx;
    logic        obs_acc;
    logic [15:0] obs_bar;
    int          obs_len = 0;
    int          acc_glitch = 0;

    always @(negedge i_clk) begin
        beat_t e;
        if (i_reset) begin
            mon_on = 1'b0;
        end else begin
            if (mon_on && (!o_click || o_overrun)) begin
                mon_on = 1'b0;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_index", obs_idx, e.idx);
                    check("sb_accent", obs_acc, e.acc);
                    check("sb_bar", obs_bar, e.bar);
                    check("sb_len", obs_len, e.len);
                end
            end
            if (o_click && !mon_on) begin
                mon_on  = 1'b1;
                obs_idx = o_beat_index;
                obs_acc = o_accent;
                obs_bar = o_bar_count;
                obs_len = 1;
            end else if (o_click) begin
                obs_len++;
            end
            if ((o_click && (o_accent != obs_acc)) || (!o_click && o_accent)) acc_glitch++;
        end
    end

    initial begin
        #1 i_reset = 1'b1;
        #2 check_zero("reset");
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        idle(3);

        // Start, three plain beats, then the wrap back to an accented downbeat
        cyc(1'b0, 1'b1, 1'b0, 5'd0);
        beats(4);

        // Deferred change to 3 beats per bar
        beats(1);
        cyc(1'b0, 1'b0, 1'b1, 5'd3);
        beats(2);
        beats(4);

        // Trigger two cycles into a click
        idle(19);
        cyc(1'b1, 1'b0, 1'b0, 5'd0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 5'd0);
        idle(19);

        // Strobe coinciding with the wrap takes effect directly
        for (int k = 0; k < 16 && ({1'b0, m_idx} != (m_active - 5'd1)); k++) beats(1);
        idle(19);
        cyc(1'b1, 1'b0, 1'b1, 5'd2);
        beats(4);

        // Pending value applied on stop; toggle with trigger drops the trigger
        idle(19);
        cyc(1'b0, 1'b0, 1'b1, 5'd5);
        idle(5);
        cyc(1'b1, 1'b1, 1'b0, 5'd0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 5'd0);
        beats(6);
        cyc(1'b0, 1'b1, 1'b0, 5'd0);
        idle(3);

        // Illegal values ignored; one beat per bar
        cyc(1'b0, 1'b0, 1'b1, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd17);
        cyc(1'b0, 1'b0, 1'b1, 5'd1);
        cyc(1'b0, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd31);
        beats(3);

        // Asynchronous reset in the middle of a click
        idle(19);
        cyc(1'b1, 1'b0, 1'b0, 5'd0);
        idle(2);
        #1 i_reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 5'd0);
        idle(5);
        cyc(1'b0, 1'b1, 1'b0, 5'd0);
        beats(5);
        idle(20);

        check("sb_drain", exp_q.size(), 0);
        check("accent_glitch", acc_glitch, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
